// File: rtl/fib_pkg.sv
// Shared types and default widths for the Fibonacci responder (fib_responder, fib_datapath).
// Optional saturation feature is selected with FIB_SATURATE_EN in the other files.
package fib_pkg;

    localparam int N_W_DEF      = 8;
    localparam int RESULT_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_datapath.sv
// Iterative Fibonacci datapath: a/b accumulators, down-counter, zero flag.
// With FIB_SATURATE_EN defined it also tracks carry-out so F(n) overflow can be reported.
module fib_datapath
    import fib_pkg::*;
#(
    parameter int N_W      = N_W_DEF,
    parameter int RESULT_W = RESULT_W_DEF
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [N_W-1:0]      n,
    input  logic                load,
    input  logic                step,
    output logic [RESULT_W-1:0] a_out,
    output logic                cnt_zero
`ifdef FIB_SATURATE_EN
    ,
    output logic                ovf_a_out
`endif
);

    logic [RESULT_W-1:0] a;
    logic [RESULT_W-1:0] b;
    logic [N_W-1:0]      cnt;

`ifdef FIB_SATURATE_EN
    logic [RESULT_W:0] sum_full;
    logic              ovf_a;
    logic              ovf_b;

    assign sum_full = {1'b0, a} + {1'b0, b};

    // ovf_b is sticky: once b has wrapped, every later b is also too large.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (load) begin
            a     <= '0;
            b     <= RESULT_W'(1);
            cnt   <= n;
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (step) begin
            a     <= b;
            b     <= sum_full[RESULT_W-1:0];
            cnt   <= cnt - N_W'(1);
            ovf_a <= ovf_b;
            ovf_b <= ovf_b | sum_full[RESULT_W];
        end
    end

    assign ovf_a_out = ovf_a;
`else
    logic [RESULT_W-1:0] sum;

    assign sum = a + b;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            a   <= '0;
            b   <= '0;
            cnt <= '0;
        end else if (load) begin
            a   <= '0;
            b   <= RESULT_W'(1);
            cnt <= n;
        end else if (step) begin
            a   <= b;
            b   <= sum;
            cnt <= cnt - N_W'(1);
        end
    end
`endif

    assign a_out    = a;
    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/fib_responder.sv
// Responder side of the n/valid/done/result Fibonacci protocol; FSM plus output registers.
// Define FIB_SATURATE_EN to clamp overflowing results to all-ones and add the overflow port.
module fib_responder
    import fib_pkg::*;
#(
    parameter int N_W      = N_W_DEF,
    parameter int RESULT_W = RESULT_W_DEF
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [N_W-1:0]      n,
    input  logic                valid,
    output logic                done,
    output logic [RESULT_W-1:0] result
`ifdef FIB_SATURATE_EN
    ,
    output logic                overflow
`endif
);

    // Handshake: four-phase. valid rises with n stable and stays high until done is
    // seen; done then stays high until valid falls. Dropping valid before done aborts.
    fib_state_e          state;
    fib_state_e          state_next;
    logic                done_next;
    logic [RESULT_W-1:0] result_next;
    logic                load;
    logic                step;
    logic [RESULT_W-1:0] a_val;
    logic                cnt_zero;

`ifdef FIB_SATURATE_EN
    logic ovf_a;
    logic overflow_next;
`endif

    fib_datapath #(
        .N_W      (N_W),
        .RESULT_W (RESULT_W)
    ) u_datapath (
        .clk       (clk),
        .aresetn   (aresetn),
        .n         (n),
        .load      (load),
        .step      (step),
        .a_out     (a_val),
        .cnt_zero  (cnt_zero)
`ifdef FIB_SATURATE_EN
        ,
        .ovf_a_out (ovf_a)
`endif
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= '0;
`ifdef FIB_SATURATE_EN
            overflow <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            done     <= done_next;
            result   <= result_next;
`ifdef FIB_SATURATE_EN
            overflow <= overflow_next;
`endif
        end
    end

    always_comb begin
        state_next    = state;
        done_next     = done;
        result_next   = result;
        load          = 1'b0;
        step          = 1'b0;
`ifdef FIB_SATURATE_EN
        overflow_next = overflow;
`endif
        case (state)
            IDLE: begin
                if (valid) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (!valid) begin
                    state_next = IDLE;
                end else if (!cnt_zero) begin
                    step = 1'b1;
                end else begin
                    done_next  = 1'b1;
                    state_next = DONE;
`ifdef FIB_SATURATE_EN
                    result_next   = ovf_a ? '1 : a_val;
                    overflow_next = ovf_a;
`else
                    result_next   = a_val;
`endif
                end
            end
            DONE: begin
                // result deliberately keeps its value after the handshake closes
                if (!valid) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
`ifdef FIB_SATURATE_EN
                    overflow_next = 1'b0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_responder.sv
// Self-checking bench for fib_responder against an exact-arithmetic Fibonacci model.
// Build with FIB_SATURATE_EN defined to exercise the saturating variant and overflow port.
module tb_fib_responder;

    localparam int N_W      = 8;
    localparam int RESULT_W = 64;
    localparam logic [191:0] MAX_RES = 192'hFFFF_FFFF_FFFF_FFFF;

    logic                clk;
    logic                aresetn;
    logic [N_W-1:0]      n;
    logic                valid;
    logic                done;
    logic [RESULT_W-1:0] result;
`ifdef FIB_SATURATE_EN
    logic                overflow;
`endif

    int errors;
    int checks;
    logic [RESULT_W-1:0] exp_q[$];
    logic                exp_ovf_q[$];
    logic [RESULT_W-1:0] last_result;

    fib_responder #(
        .N_W      (N_W),
        .RESULT_W (RESULT_W)
    ) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .n        (n),
        .valid    (valid),
        .done     (done),
        .result   (result)
`ifdef FIB_SATURATE_EN
        ,
        .overflow (overflow)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exact Fibonacci in a width that holds F(255) without wrapping
    function automatic logic [191:0] fib_exact(input int k);
        logic [191:0] x;
        logic [191:0] y;
        logic [191:0] t;
        x = 192'd0;
        y = 192'd1;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int k);
        logic [191:0] exact;
        exact = fib_exact(k);
`ifdef FIB_SATURATE_EN
        if (exact > MAX_RES) begin
            exp_q.push_back({RESULT_W{1'b1}});
            exp_ovf_q.push_back(1'b1);
        end else begin
            exp_q.push_back(exact[RESULT_W-1:0]);
            exp_ovf_q.push_back(1'b0);
        end
`else
        exp_q.push_back(exact[RESULT_W-1:0]);
        exp_ovf_q.push_back(1'b0);
`endif
    endtask

    // driver: one full four-phase transaction, checked against the scoreboard
    task automatic run_request(input logic [N_W-1:0] req_n, input bit toggle_n, input int hold_cycles);
        logic [RESULT_W-1:0] exp;
        logic                exp_ovf;
        int                  edges;
        bit                  got;
        push_expected(int'(req_n));
        n     = req_n;
        valid = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 300) begin
            tick();
            edges++;
            if (done) got = 1'b1;
            else if (toggle_n) n = N_W'($urandom_range(0, 255));
        end
        exp     = exp_q.pop_front();
        exp_ovf = exp_ovf_q.pop_front();
        checks++;
        if (!got || edges != int'(req_n) + 2) begin
            errors++;
            $display("FAIL latency n=%0d: got %0d edges (done=%0b), expected %0d", req_n, edges, got, int'(req_n) + 2);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL result n=%0d: got %0d, expected %0d", req_n, result, exp);
        end
`ifdef FIB_SATURATE_EN
        checks++;
        if (overflow !== exp_ovf) begin
            errors++;
            $display("FAIL overflow n=%0d: got %0b, expected %0b", req_n, overflow, exp_ovf);
        end
`else
        if (exp_ovf !== 1'b0) $display("note: unexpected model overflow flag");
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || result !== exp) begin
                errors++;
                $display("FAIL hold n=%0d: done=%0b result=%0d, expected done=1 result=%0d", req_n, done, result, exp);
            end
        end
        valid = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL release n=%0d: done=%0b result=%0d, expected done=0 result=%0d", req_n, done, result, exp);
        end
`ifdef FIB_SATURATE_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_release n=%0d: got %0b, expected 0", req_n, overflow);
        end
`endif
        last_result = exp;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        valid   = 1'b0;
        n       = '0;
        repeat (3) tick();
        checks++;
        if (done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset: done=%0b result=%0d, expected done=0 result=0", done, result);
        end
`ifdef FIB_SATURATE_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: got %0b, expected 0", overflow);
        end
`endif
        aresetn = 1'b1;
        tick();
        last_result = '0;
    endtask

    task automatic test_basic();
        run_request(8'd1, 1'b0, 2);
        run_request(8'd10, 1'b0, 1);
        run_request(8'd0, 1'b0, 0);
    endtask

    task automatic test_boundary();
        run_request(8'd93, 1'b0, 1);
        run_request(8'd94, 1'b0, 1);
        run_request(8'd255, 1'b1, 0);
    endtask

    task automatic test_reset_mid_calc();
        n     = 8'd50;
        valid = 1'b1;
        repeat (10) tick();
        aresetn = 1'b0;
        valid   = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid: done=%0b result=%0d, expected done=0 result=0", done, result);
        end
        aresetn = 1'b1;
        repeat (60) tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: done=%0b, expected 0", done);
        end
        run_request(8'd7, 1'b0, 0);
    endtask

    task automatic test_abort();
        int seen_done;
        n         = 8'd40;
        valid     = 1'b1;
        seen_done = 0;
        repeat (10) tick();
        valid = 1'b0;
        repeat (60) begin
            tick();
            if (done) seen_done++;
        end
        checks++;
        if (seen_done != 0 || result !== last_result) begin
            errors++;
            $display("FAIL abort: done high %0d cycles, result=%0d, expected 0 cycles result=%0d", seen_done, result, last_result);
        end
        run_request(8'd5, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 254; k++) begin
            run_request(N_W'(k), 1'b1, $urandom_range(0, 2));
            repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        aresetn = 1'b0;
        valid   = 1'b0;
        n       = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_reset_mid_calc();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
